mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 1024, cycles without mem_ready before abort; 0 disables timeout.
REQ-002 Port: clock  in  1  single clock; all state on rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-low reset.
REQ-004 Ports: imem_valid/imem_instr in 1, imem_addr/imem_wdata in 32, imem_wstrb in 4, imem_rdata out 32, imem_ready out 1: CPU instruction-side request/response.
REQ-005 Ports: dmem_valid/dmem_instr in 1, dmem_addr/dmem_wdata in 32, dmem_wstrb in 4, dmem_rdata out 32, dmem_ready out 1: CPU data-side request/response.
REQ-006 Ports: mem_valid/mem_instr out 1, mem_addr/mem_wdata out 32, mem_wstrb out 4, mem_rdata in 32, mem_ready in 1: shared memory bus.
REQ-007 Port: err  out  1  sticky flag for overrun or timeout.

Function
REQ-008 *_valid is a one-cycle pulse; on the pulse, valid/instr/addr/wdata/wstrb SHALL be captured into that port's pending slot (one slot per port).
REQ-009 FSM states: IDLE, IBUSY, DBUSY; at most one transaction outstanding on the shared bus.
REQ-010 IDLE with a pending slot (including one captured this cycle is NOT eligible until next cycle): grant, pulse mem_valid one cycle next cycle, go to IBUSY/DBUSY, clear that slot.
REQ-011 mem_addr/mem_wdata/mem_wstrb/mem_instr SHALL be registered and stable from issue until mem_ready.
REQ-012 In IBUSY, imem_rdata = mem_rdata and imem_ready = mem_ready combinationally; DBUSY likewise for dmem; non-owner ready stays 0, rdata 0.
REQ-013 On mem_ready in xBUSY: return to IDLE; if a slot is pending, the next mem_valid issues no earlier than the following cycle.
REQ-014 Both slots pending in IDLE: data wins (tie rule, see REQ-021).
REQ-015 Valid pulse on a port whose slot is pending or whose transaction is in flight: new request dropped, err set.
REQ-016 Wait counter (width ceil log2(TIMEOUT+1)) counts xBUSY cycles; reaching TIMEOUT with no mem_ready: owner gets ready=1, rdata=0 for one cycle, err set, return to IDLE; a later stray mem_ready in IDLE is ignored.
REQ-017 mem_ready while IDLE SHALL be ignored.

Reset
REQ-018 reset low: state IDLE, slots empty, counter 0, err 0, mem_valid 0, mem_addr/wdata 0, mem_wstrb 0, mem_instr 0, last-grant = instruction; in-flight transaction discarded, no ready delivered.
REQ-019 Outputs imem_ready/dmem_ready SHALL be 0 throughout reset.

Configuration
REQ-020 Macro MEM_ARBITER_RR_EN selects tie policy.
REQ-021 Defined: on tie grant the port not granted last (round-robin; first tie after reset grants data); undefined: data always wins.

Structure
REQ-022 State enum and mem_in_type/mem_out_type style records belong in package wires; TIMEOUT default as a constant there.
REQ-023 One sub-module natural: mem_arbiter_slot (pending-request register, instantiated twice).

Verification
REQ-024 Single dmem read addr 0x100 -> mem_valid one cycle later, mem_addr 0x100; mem_ready+rdata 0xDEADBEEF after 3 cycles -> dmem_ready with 0xDEADBEEF same cycle, imem_ready 0.
REQ-025 Simultaneous imem 0x0 and dmem 0x200 pulses -> dmem issued first, imem issued cycle after dmem ready; without macro repeat -> data first again; with macro second tie -> instruction first.
REQ-026 Store dmem wdata 0x12345678 wstrb 0x3, ready delayed 10 cycles -> mem_wdata/wstrb stable all 10 cycles, err 0.
REQ-027 TIMEOUT=8, never assert mem_ready -> after 8 busy cycles owner ready=1 rdata=0, err=1, FSM IDLE.
REQ-028 Second imem pulse while first in flight -> dropped, err=1, only one imem transaction on bus.
REQ-029 reset low mid-DBUSY -> mem_valid 0, no dmem_ready, err 0; after release new request served normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the two-port memory arbiter.
//   - FSM state encodings (idle, instruction-side busy, data-side busy)
//   - mem_in_t:  one memory request (instr flag, address, write data, byte strobes)
//   - mem_out_t: one per-port response (read data, ready)
//   - TimeoutDefault: default wait budget before a stuck bus transaction is aborted
package mem_arbiter_pkg;

  localparam int unsigned TimeoutDefault = 1024;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIBusy = 2'd1;
  localparam logic [1:0] StDBusy = 2'd2;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_in_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        ready;
  } mem_out_t;

  localparam int unsigned ReqW = $bits(mem_in_t);

  // Wait counter must hold the value TIMEOUT itself; keep at least one bit when disabled.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_slot.sv
// mem_arbiter_slot: single-entry pending-request register for one CPU port.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   valid_i       : one-cycle request pulse; req_i is captured on it
//   req_i         : packed request (mem_in_t layout)
//   busy_i        : this port currently owns the shared bus
//   clear_i       : request has been granted, empty the slot
//   pending_o     : slot holds a request
//   req_o         : captured request
//   overrun_o     : pulse arrived while the slot was full or the port was busy (request dropped)
module mem_arbiter_slot
  import mem_arbiter_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  input  logic [ReqW-1:0] req_i,
  input  logic            busy_i,
  input  logic            clear_i,
  output logic            pending_o,
  output logic [ReqW-1:0] req_o,
  output logic            overrun_o
);

  logic            pending_q, pending_d;
  logic [ReqW-1:0] req_q, req_d;
  logic            capture;

  assign capture   = valid_i & ~pending_q & ~busy_i;
  assign overrun_o = valid_i & (pending_q | busy_i);

  // clear_i only fires while pending, so it never collides with capture.
  always_comb begin
    pending_d = pending_q;
    req_d     = req_q;
    if (clear_i) begin
      pending_d = 1'b0;
    end
    if (capture) begin
      pending_d = 1'b1;
      req_d     = req_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= 1'b0;
      req_q     <= '0;
    end else begin
      pending_q <= pending_d;
      req_q     <= req_d;
    end
  end

  assign pending_o = pending_q;
  assign req_o     = req_q;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates CPU instruction and data ports onto one shared memory bus,
// with at most one transaction outstanding.
//   clk_i, rst_ni              : clock, asynchronous active-low reset
//   imem_* (valid/instr/addr/wdata/wstrb in, rdata/ready out) : instruction-side port
//   dmem_* (valid/instr/addr/wdata/wstrb in, rdata/ready out) : data-side port
//   mem_*  (valid/instr/addr/wdata/wstrb out, rdata/ready in) : shared memory bus
//   err_o                      : sticky; set on a dropped (overrun) request or a timeout
// Parameter TIMEOUT: busy cycles without mem_ready_i before abort (0 disables).
// Build option MEM_ARBITER_RR_EN: when defined, simultaneous requests alternate between
// ports (first tie after reset goes to data); otherwise data always wins a tie.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        imem_valid_i,
  input  logic        imem_instr_i,
  input  logic [31:0] imem_addr_i,
  input  logic [31:0] imem_wdata_i,
  input  logic [3:0]  imem_wstrb_i,
  output logic [31:0] imem_rdata_o,
  output logic        imem_ready_o,
  input  logic        dmem_valid_i,
  input  logic        dmem_instr_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_wdata_i,
  input  logic [3:0]  dmem_wstrb_i,
  output logic [31:0] dmem_rdata_o,
  output logic        dmem_ready_o,
  output logic        mem_valid_o,
  output logic        mem_instr_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i,
  output logic        err_o
);

  localparam int unsigned    CntW   = cnt_width(TIMEOUT);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mem_valid_q, mem_valid_d;
  mem_in_t         mem_req_q, mem_req_d;
  logic            err_q, err_d;

  mem_in_t         i_in, d_in, i_req, d_req;
  logic [ReqW-1:0] i_req_raw, d_req_raw;
  logic            i_pend, d_pend, i_ovr, d_ovr, i_clr, d_clr;
  logic            busy, tmo, done, grant, pick_d;
  mem_out_t        i_rsp, d_rsp;
  logic [31:0]     rsp_rdata;

  assign i_in = '{instr: imem_instr_i, addr: imem_addr_i, wdata: imem_wdata_i,
                  wstrb: imem_wstrb_i};
  assign d_in = '{instr: dmem_instr_i, addr: dmem_addr_i, wdata: dmem_wdata_i,
                  wstrb: dmem_wstrb_i};

  mem_arbiter_slot u_islot (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid_i  (imem_valid_i),
    .req_i    (i_in),
    .busy_i   (state_q == StIBusy),
    .clear_i  (i_clr),
    .pending_o(i_pend),
    .req_o    (i_req_raw),
    .overrun_o(i_ovr)
  );

  mem_arbiter_slot u_dslot (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid_i  (dmem_valid_i),
    .req_i    (d_in),
    .busy_i   (state_q == StDBusy),
    .clear_i  (d_clr),
    .pending_o(d_pend),
    .req_o    (d_req_raw),
    .overrun_o(d_ovr)
  );

  assign i_req = mem_in_t'(i_req_raw);
  assign d_req = mem_in_t'(d_req_raw);

  assign busy  = (state_q != StIdle);
  // Abort only when the budget is exhausted and the bus did not answer this very cycle.
  assign tmo   = (TIMEOUT != 0) && busy && (cnt_q == CntMax) && !mem_ready_i;
  assign done  = busy & (mem_ready_i | tmo);
  assign grant = (state_q == StIdle) & (i_pend | d_pend);

`ifdef MEM_ARBITER_RR_EN
  // last_d_q remembers which port won the most recent tie (0 = instruction). Only ties
  // update it, so back-to-back ties alternate regardless of untied traffic in between.
  logic last_d_q, last_d_d;

  assign pick_d = (i_pend & d_pend) ? ~last_d_q : d_pend;

  always_comb begin
    last_d_d = last_d_q;
    if (grant && i_pend && d_pend) begin
      last_d_d = pick_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_d_q <= 1'b0;
    end else begin
      last_d_q <= last_d_d;
    end
  end
`else
  assign pick_d = d_pend;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_valid_d = 1'b0;
    mem_req_d   = mem_req_q;
    err_d       = err_q | i_ovr | d_ovr | tmo;
    i_clr       = 1'b0;
    d_clr       = 1'b0;
    case (state_q)
      StIdle: begin
        // Stray mem_ready_i here is ignored by construction.
        if (grant) begin
          mem_valid_d = 1'b1;
          cnt_d       = '0;
          if (pick_d) begin
            state_d   = StDBusy;
            mem_req_d = d_req;
            d_clr     = 1'b1;
          end else begin
            state_d   = StIBusy;
            mem_req_d = i_req;
            i_clr     = 1'b1;
          end
        end
      end
      StIBusy, StDBusy: begin
        if (done) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mem_valid_q <= 1'b0;
      mem_req_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_valid_q <= mem_valid_d;
      mem_req_q   <= mem_req_d;
      err_q       <= err_d;
    end
  end

  // Owner sees the bus combinationally; an aborted transaction returns zero data.
  assign rsp_rdata = tmo ? 32'h0 : mem_rdata_i;
  assign i_rsp = '{rdata: (state_q == StIBusy) ? rsp_rdata : 32'h0,
                   ready: (state_q == StIBusy) & done};
  assign d_rsp = '{rdata: (state_q == StDBusy) ? rsp_rdata : 32'h0,
                   ready: (state_q == StDBusy) & done};

  assign imem_rdata_o = i_rsp.rdata;
  assign imem_ready_o = i_rsp.ready;
  assign dmem_rdata_o = d_rsp.rdata;
  assign dmem_ready_o = d_rsp.ready;

  assign mem_valid_o = mem_valid_q;
  assign mem_instr_o = mem_req_q.instr;
  assign mem_addr_o  = mem_req_q.addr;
  assign mem_wdata_o = mem_req_q.wdata;
  assign mem_wstrb_o = mem_req_q.wstrb;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected bus issues and port
// responses into queues; monitors pop and compare whenever the DUT presents them.
// A second instance with TIMEOUT=8 exercises the abort path.
module tb_mem_arbiter;

  typedef struct {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } iss_t;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance stimulus / observation
  logic        imem_valid = 0, imem_instr = 0, dmem_valid = 0, dmem_instr = 0;
  logic [31:0] imem_addr = 0, imem_wdata = 0, dmem_addr = 0, dmem_wdata = 0;
  logic [3:0]  imem_wstrb = 0, dmem_wstrb = 0;
  logic [31:0] imem_rdata, dmem_rdata, mem_addr, mem_wdata;
  logic        imem_ready, dmem_ready, mem_valid, mem_instr, err;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 0;
  logic [31:0] mem_rdata = 0;

  // Timeout instance
  logic        t_imem_valid = 0, t_dmem_valid = 0, t_mem_ready = 0;
  logic [31:0] t_imem_addr = 0, t_dmem_addr = 0;
  logic [31:0] t_mem_rdata = 32'hFFFF_FFFF;
  logic [31:0] t_imem_rdata, t_dmem_rdata, t_mem_addr, t_mem_wdata;
  logic        t_imem_ready, t_dmem_ready, t_mem_valid, t_mem_instr, t_err;
  logic [3:0]  t_mem_wstrb;

  int checks = 0;
  int errors = 0;

  iss_t exp_iss[$];
  rsp_t exp_rsp[$];

  int resp_delay = 3;
  bit no_resp = 0;

  mem_arbiter #(.TIMEOUT(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_valid_i(imem_valid), .imem_instr_i(imem_instr), .imem_addr_i(imem_addr),
    .imem_wdata_i(imem_wdata), .imem_wstrb_i(imem_wstrb), .imem_rdata_o(imem_rdata),
    .imem_ready_o(imem_ready),
    .dmem_valid_i(dmem_valid), .dmem_instr_i(dmem_instr), .dmem_addr_i(dmem_addr),
    .dmem_wdata_i(dmem_wdata), .dmem_wstrb_i(dmem_wstrb), .dmem_rdata_o(dmem_rdata),
    .dmem_ready_o(dmem_ready),
    .mem_valid_o(mem_valid), .mem_instr_o(mem_instr), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb), .mem_rdata_i(mem_rdata),
    .mem_ready_i(mem_ready), .err_o(err)
  );

  mem_arbiter #(.TIMEOUT(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_valid_i(t_imem_valid), .imem_instr_i(1'b1), .imem_addr_i(t_imem_addr),
    .imem_wdata_i(32'h0), .imem_wstrb_i(4'h0), .imem_rdata_o(t_imem_rdata),
    .imem_ready_o(t_imem_ready),
    .dmem_valid_i(t_dmem_valid), .dmem_instr_i(1'b0), .dmem_addr_i(t_dmem_addr),
    .dmem_wdata_i(32'h0), .dmem_wstrb_i(4'h0), .dmem_rdata_o(t_dmem_rdata),
    .dmem_ready_o(t_dmem_ready),
    .mem_valid_o(t_mem_valid), .mem_instr_o(t_mem_instr), .mem_addr_o(t_mem_addr),
    .mem_wdata_o(t_mem_wdata), .mem_wstrb_o(t_mem_wstrb), .mem_rdata_i(t_mem_rdata),
    .mem_ready_i(t_mem_ready), .err_o(t_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    logic [15:0] lo;
    lo = a[15:0];
    return (a == 32'h100) ? 32'hDEAD_BEEF : {lo, 16'hC0DE};
  endfunction

  // Memory responder: answers each issue after resp_delay cycles, checking the
  // request stays stable while waiting.
  always begin
    logic [31:0] a, w;
    logic [3:0]  s;
    logic        ins;
    @(posedge clk); #1;
    if (mem_valid && !no_resp) begin
      a = mem_addr; w = mem_wdata; s = mem_wstrb; ins = mem_instr;
      for (int i = 0; i < resp_delay; i++) begin
        @(posedge clk); #1;
        chk("bus_addr_stable", mem_addr, a);
        chk("bus_wdata_stable", mem_wdata, w);
        chk("bus_wstrb_stable", {28'h0, mem_wstrb}, {28'h0, s});
        chk("bus_instr_stable", {31'h0, mem_instr}, {31'h0, ins});
      end
      mem_ready = 1'b1;
      mem_rdata = mem_model(a);
      @(posedge clk); #1;
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
    end
  end

  // Issue monitor
  always @(negedge clk) begin
    if (mem_valid) begin
      if (exp_iss.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_issue: got addr %h, expected no issue", mem_addr);
      end else begin
        iss_t e;
        e = exp_iss.pop_front();
        chk("issue_instr", {31'h0, mem_instr}, {31'h0, e.instr});
        chk("issue_addr", mem_addr, e.addr);
        chk("issue_wdata", mem_wdata, e.wdata);
        chk("issue_wstrb", {28'h0, mem_wstrb}, {28'h0, e.wstrb});
      end
    end
  end

  // Response monitor
  always @(negedge clk) begin
    if (imem_ready || dmem_ready) begin
      chk("single_owner_ready", {31'h0, imem_ready & dmem_ready}, 32'h0);
      chk("nonowner_rdata", dmem_ready ? imem_rdata : dmem_rdata, 32'h0);
      if (exp_rsp.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_response: got imem %b dmem %b, expected none",
                 imem_ready, dmem_ready);
      end else begin
        rsp_t r;
        r = exp_rsp.pop_front();
        chk("rsp_port_is_d", {31'h0, dmem_ready}, {31'h0, r.is_d});
        chk("rsp_rdata", dmem_ready ? dmem_rdata : imem_rdata, r.rdata);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
    imem_valid = 1'b0;
    dmem_valid = 1'b0;
  endtask

  task automatic set_req(input bit is_d, input logic ins, input logic [31:0] a,
                         input logic [31:0] w, input logic [3:0] s);
    if (is_d) begin
      dmem_valid = 1'b1; dmem_instr = ins; dmem_addr = a; dmem_wdata = w; dmem_wstrb = s;
    end else begin
      imem_valid = 1'b1; imem_instr = ins; imem_addr = a; imem_wdata = w; imem_wstrb = s;
    end
  endtask

  task automatic expect_txn(input bit is_d, input logic ins, input logic [31:0] a,
                            input logic [31:0] w, input logic [3:0] s,
                            input logic [31:0] rd);
    exp_iss.push_back('{instr: ins, addr: a, wdata: w, wstrb: s});
    exp_rsp.push_back('{is_d: is_d, rdata: rd});
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_iss.size() != 0 || exp_rsp.size() != 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s: got %0d issues / %0d responses outstanding, expected 0",
               name, exp_iss.size(), exp_rsp.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    // Reset state
    repeat (2) begin
      @(negedge clk);
      chk("rst_imem_ready", {31'h0, imem_ready}, 32'h0);
      chk("rst_dmem_ready", {31'h0, dmem_ready}, 32'h0);
    end
    chk("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single data read: issue one cycle after the slot becomes eligible
    resp_delay = 3;
    expect_txn(1, 1'b0, 32'h100, 32'h0, 4'h0, 32'hDEAD_BEEF);
    set_req(1, 1'b0, 32'h100, 32'h0, 4'h0);
    step();
    n = 0;
    while (!mem_valid && n < 10) begin @(posedge clk); #1; n++; end
    chk("issue_latency", n, 1);
    wait_idle("single_read");

    // Tie: data first in every build
    resp_delay = 2;
    expect_txn(1, 1'b0, 32'h200, 32'h0, 4'h0, 32'h0200_C0DE);
    expect_txn(0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0000_C0DE);
    set_req(0, 1'b1, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'h200, 32'h0, 4'h0);
    step();
    n = 0;
    while (!dmem_ready && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (!mem_valid && n < 10) begin @(posedge clk); #1; n++; end
    chk("tie_second_issue_gap", n, 2);
    wait_idle("tie1");

    // Second tie: round-robin hands it to instruction, fixed priority to data
`ifdef MEM_ARBITER_RR_EN
    expect_txn(0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0000_C0DE);
    expect_txn(1, 1'b0, 32'h200, 32'h0, 4'h0, 32'h0200_C0DE);
`else
    expect_txn(1, 1'b0, 32'h200, 32'h0, 4'h0, 32'h0200_C0DE);
    expect_txn(0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0000_C0DE);
`endif
    set_req(0, 1'b1, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'h200, 32'h0, 4'h0);
    step();
    wait_idle("tie2");

    // Store with slow memory: bus held stable for 10 cycles
    resp_delay = 10;
    expect_txn(1, 1'b0, 32'h300, 32'h1234_5678, 4'h3, 32'h0300_C0DE);
    set_req(1, 1'b0, 32'h300, 32'h1234_5678, 4'h3);
    step();
    wait_idle("store");
    chk("store_err", {31'h0, err}, 32'h0);

    // Overrun: second instruction pulse while the first is in flight is dropped
    resp_delay = 5;
    expect_txn(0, 1'b1, 32'h40, 32'h0, 4'h0, 32'h0040_C0DE);
    set_req(0, 1'b1, 32'h40, 32'h0, 4'h0);
    step();
    repeat (2) @(posedge clk);
    #1;
    set_req(0, 1'b1, 32'h80, 32'h0, 4'h0);
    step();
    chk("overrun_err", {31'h0, err}, 32'h1);
    wait_idle("overrun");

    // Reset in the middle of a data transaction
    no_resp = 1;
    exp_iss.push_back('{instr: 1'b0, addr: 32'h500, wdata: 32'h0, wstrb: 4'h0});
    set_req(1, 1'b0, 32'h500, 32'h0, 4'h0);
    step();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("midrst_mem_valid", {31'h0, mem_valid}, 32'h0);
      chk("midrst_dmem_ready", {31'h0, dmem_ready}, 32'h0);
      chk("midrst_err", {31'h0, err}, 32'h0);
    end
    chk("issue_before_reset", exp_iss.size(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    no_resp = 0;
    resp_delay = 1;
    @(posedge clk); #1;
    expect_txn(1, 1'b0, 32'h100, 32'h0, 4'h0, 32'hDEAD_BEEF);
    set_req(1, 1'b0, 32'h100, 32'h0, 4'h0);
    step();
    wait_idle("after_reset");
    chk("after_reset_err", {31'h0, err}, 32'h0);

    // Timeout on the TIMEOUT=8 instance; memory never answers
    t_dmem_addr = 32'h700;
    t_dmem_valid = 1'b1;
    @(posedge clk); #1;
    t_dmem_valid = 1'b0;
    n = 0;
    while (!t_mem_valid && n < 10) begin @(posedge clk); #1; n++; end
    chk("tmo_issue_addr", t_mem_addr, 32'h700);
    n = 0;
    while (!t_dmem_ready && n < 30) begin @(posedge clk); #1; n++; end
    chk("tmo_busy_cycles", n, 8);
    chk("tmo_rdata", t_dmem_rdata, 32'h0);
    chk("tmo_imem_ready", {31'h0, t_imem_ready}, 32'h0);
    @(posedge clk); #1;
    chk("tmo_err", {31'h0, t_err}, 32'h1);
    chk("tmo_ready_one_cycle", {31'h0, t_dmem_ready}, 32'h0);
    t_mem_ready = 1'b1;
    #1;
    chk("stray_ready_dmem", {31'h0, t_dmem_ready}, 32'h0);
    chk("stray_ready_imem", {31'h0, t_imem_ready}, 32'h0);
    @(posedge clk); #1;
    t_mem_ready = 1'b0;
    t_imem_addr = 32'h740;
    t_imem_valid = 1'b1;
    @(posedge clk); #1;
    t_imem_valid = 1'b0;
    n = 0;
    while (!t_mem_valid && n < 10) begin @(posedge clk); #1; n++; end
    chk("tmo_idle_new_issue", n, 1);
    chk("tmo_idle_new_addr", t_mem_addr, 32'h740);
    chk("tmo_idle_new_instr", {31'h0, t_mem_instr}, 32'h1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
